// File: rtl/vc_vr_arb_if.sv
// vc_vr_arb_if: credit-based sender side and valid/ready receiver side of the converter
interface vc_vr_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  logic [DATA_WIDTH-1:0] s_data_i;
  logic [CH_W-1:0]       s_ch_i;
  logic                  s_valid_i;
  logic [NUM_CH-1:0]     s_credit_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic [CH_W-1:0]       m_ch_o;
  logic                  m_valid_o;
  logic                  m_ready_i;
  logic                  err_o;
  modport slave (
    input  s_data_i, s_ch_i, s_valid_i, m_ready_i,
    output s_credit_o, m_data_o, m_ch_o, m_valid_o, err_o
  );
  modport master (
    output s_data_i, s_ch_i, s_valid_i, m_ready_i,
    input  s_credit_o, m_data_o, m_ch_o, m_valid_o, err_o
  );
endinterface

// File: rtl/vc_vr_arb_converter.sv
// vc_vr_arb_converter: per-channel credit FIFOs merged round-robin onto one registered valid/ready output
module vc_vr_arb_converter #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2,
  parameter int NUM_CH     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  vc_vr_arb_if.slave   bus
);
  localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int CW   = $clog2(CREDIT_NUM + 1);
  localparam int PW   = CREDIT_NUM > 1 ? $clog2(CREDIT_NUM) : 1;
  logic [DATA_WIDTH-1:0] mem [NUM_CH][CREDIT_NUM];
  logic [CW-1:0]         cnt_q  [NUM_CH];
  logic [PW-1:0]         wptr_q [NUM_CH];
  logic [PW-1:0]         rptr_q [NUM_CH];
  logic [CH_W-1:0]       last_q, gnt, m_ch_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q, err_q, found, load, drop;
  logic [NUM_CH-1:0]     pop, push, credit_q;
  // search starts one past the last granted channel, wrapping
  always_comb begin
    gnt = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++)
      if (!found && cnt_q[(int'(last_q) + i) % NUM_CH] != '0) begin
        found = 1'b1;
        gnt = CH_W'((int'(last_q) + i) % NUM_CH);
      end
  end
  assign load = found && (!m_valid_q || bus.m_ready_i);
  assign pop  = load ? NUM_CH'(1) << gnt : '0;
  // a full channel still accepts when it pops on the same edge
  always_comb begin
    push = '0;
    drop = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (bus.s_valid_i && bus.s_ch_i == CH_W'(c)) begin
        if (cnt_q[c] != CW'(CREDIT_NUM) || pop[c]) push[c] = 1'b1;
        else drop = 1'b1;
      end
    if (bus.s_valid_i && int'(bus.s_ch_i) >= NUM_CH) drop = 1'b1;
  end
  always_ff @(posedge clk)
    for (int c = 0; c < NUM_CH; c++)
      if (push[c]) mem[c][wptr_q[c]] <= bus.s_data_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c]  <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      last_q    <= CH_W'(NUM_CH - 1);
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_ch_q    <= '0;
      credit_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cnt_q[c] <= cnt_q[c] + CW'(push[c]) - CW'(pop[c]);
        if (push[c]) wptr_q[c] <= wptr_q[c] == PW'(CREDIT_NUM - 1) ? '0 : wptr_q[c] + 1'b1;
        if (pop[c]) rptr_q[c] <= rptr_q[c] == PW'(CREDIT_NUM - 1) ? '0 : rptr_q[c] + 1'b1;
      end
      credit_q <= pop;
      err_q    <= err_q | drop;
      if (load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= mem[gnt][rptr_q[gnt]];
        m_ch_q    <= gnt;
        last_q    <= gnt;
      end else if (bus.m_ready_i) m_valid_q <= 1'b0;
    end
  assign bus.m_valid_o  = m_valid_q;
  assign bus.m_data_o   = m_data_q;
  assign bus.m_ch_o     = m_ch_q;
  assign bus.s_credit_o = credit_q;
  assign bus.err_o      = err_q;
endmodule

// File: tb/tb_vc_vr_arb_converter.sv
// tb_vc_vr_arb_converter: queue-based reference model, directed scenarios plus credit-respecting random traffic
module tb_vc_vr_arb_converter;
  localparam int DW = 8, CN = 2, NCH = 4;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  vc_vr_arb_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();
  vc_vr_arb_converter #(.DATA_WIDTH(DW), .CREDIT_NUM(CN), .NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  int total = 0, bad = 0;
  logic [DW-1:0] q [NCH][$];
  logic exp_v, exp_err;
  logic [DW-1:0] exp_d;
  logic [NCH-1:0] exp_cr;
  int exp_c, last, cr_seen;
  int credits [NCH];
  int got_ch [$];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      q[c].delete();
      credits[c] = CN;
    end
    exp_v = 1'b0; exp_d = '0; exp_c = 0; exp_cr = '0; exp_err = 1'b0; last = NCH - 1;
  endtask
  // one clock edge of the spec's behaviour, using the inputs present at that edge
  task automatic model_edge();
    int g = -1;
    int ch = int'(bus.s_ch_i);
    bit wr = 1'b0;
    logic [NCH-1:0] cr = '0;
    if (!exp_v || bus.m_ready_i)
      for (int i = 1; i <= NCH; i++)
        if (g < 0 && q[(last + i) % NCH].size() > 0) g = (last + i) % NCH;
    if (bus.s_valid_i) begin
      if (ch >= NCH) exp_err = 1'b1;
      else if (q[ch].size() < CN || g == ch) wr = 1'b1;
      else exp_err = 1'b1;
    end
    if (g >= 0) begin
      exp_d = q[g].pop_front();
      exp_c = g; exp_v = 1'b1; last = g; cr[g] = 1'b1;
    end else if (exp_v && bus.m_ready_i) exp_v = 1'b0;
    if (wr) q[ch].push_back(bus.s_data_i);
    exp_cr = cr;
  endtask
  task automatic check_outputs();
    check("m_valid", bus.m_valid_o, exp_v);
    check("m_data", bus.m_data_o, exp_d);
    check("m_ch", bus.m_ch_o, exp_c);
    check("credit", bus.s_credit_o, exp_cr);
    check("err", bus.err_o, exp_err);
  endtask
  task automatic cycle(input logic v, input int ch, input logic [DW-1:0] d, input logic rdy);
    bus.s_valid_i = v; bus.s_ch_i = ch[1:0]; bus.s_data_i = d; bus.m_ready_i = rdy;
    if (bus.m_valid_o && bus.m_ready_i) got_ch.push_back(int'(bus.m_ch_o));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    cr_seen += $countones(bus.s_credit_o);
    for (int c = 0; c < NCH; c++) credits[c] += int'(exp_cr[c]);
  endtask
  task automatic do_reset();
    bus.s_valid_i = 1'b0; bus.s_ch_i = '0; bus.s_data_i = '0; bus.m_ready_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_async_valid", bus.m_valid_o, 0);
    check("rst_async_credit", bus.s_credit_o, 0);
    model_clear();
    repeat (10) begin
      @(posedge clk);
      #1;
      check("rst_hold_credit", bus.s_credit_o, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs();
    check("rst_data", bus.m_data_o, 0);
    check("rst_err", bus.err_o, 0);
  endtask
  initial begin
    logic [DW-1:0] held_d;
    int n2;
    rst_n = 1'b1;
    bus.s_valid_i = 1'b0; bus.s_ch_i = '0; bus.s_data_i = '0; bus.m_ready_i = 1'b0;
    cr_seen = 0;
    #2;
    do_reset();
    // single beat: latency and credit return
    cycle(1, 1, 8'hA5, 1);
    check("lat_pre_valid", bus.m_valid_o, 0);
    cycle(0, 0, 0, 1);
    check("lat_valid", bus.m_valid_o, 1);
    check("lat_data", bus.m_data_o, 8'hA5);
    check("lat_ch", bus.m_ch_o, 1);
    check("lat_credit", bus.s_credit_o, 4'b0010);
    cycle(0, 0, 0, 1);
    check("lat_credit_off", bus.s_credit_o, 0);
    // two beats per channel buffered, then drained round-robin
    cr_seen = 0;
    for (int j = 0; j < 2; j++)
      for (int c = 0; c < NCH; c++) cycle(1, c, 8'(16 * c + j + 1), 0);
    got_ch.delete();
    repeat (12) cycle(0, 0, 0, 1);
    check("rr_count", got_ch.size(), 8);
    for (int i = 0; i < 8 && i < got_ch.size(); i++) check("rr_order", got_ch[i], i % NCH);
    check("rr_credits", cr_seen, 8);
    check("rr_err", bus.err_o, 0);
    // overflow on ch2 while the output register holds a ch0 beat
    cycle(1, 0, 8'h01, 0);
    cycle(1, 2, 8'h21, 0);
    cycle(1, 2, 8'h22, 0);
    cycle(1, 2, 8'h23, 0);
    check("ovf_err", bus.err_o, 1);
    got_ch.delete();
    repeat (6) cycle(0, 0, 0, 1);
    n2 = 0;
    foreach (got_ch[i]) if (got_ch[i] == 2) n2++;
    check("ovf_ch2_drained", n2, 2);
    // stall: output holds with no extra pops or credits
    cycle(1, 3, 8'h7E, 0);
    cycle(1, 1, 8'h5B, 0);
    cycle(0, 0, 0, 0);
    held_d = bus.m_data_o;
    cr_seen = 0;
    repeat (5) begin
      cycle(0, 0, 0, 0);
      check("stall_data", bus.m_data_o, held_d);
      check("stall_ch", bus.m_ch_o, 3);
    end
    check("stall_credits", cr_seen, 0);
    repeat (4) cycle(0, 0, 0, 1);
    // reset in the middle of a burst
    cycle(1, 0, 8'h31, 0);
    cycle(1, 1, 8'h32, 0);
    cycle(1, 2, 8'h33, 0);
    cycle(1, 3, 8'h34, 0);
    do_reset();
    cycle(1, 3, 8'h3C, 1);
    check("post_rst_pre", bus.m_valid_o, 0);
    cycle(0, 0, 0, 1);
    check("post_rst_data", bus.m_data_o, 8'h3C);
    check("post_rst_valid", bus.m_valid_o, 1);
    cycle(0, 0, 0, 1);
    // random traffic that respects returned credits
    do_reset();
    repeat (400) begin
      int ch = $urandom_range(0, NCH - 1);
      logic v = ($urandom_range(0, 9) < 7) && credits[ch] > 0;
      if (v) credits[ch]--;
      cycle(v, ch, 8'($urandom), $urandom_range(0, 9) < 7);
    end
    repeat (12) cycle(0, 0, 0, 1);
    check("rand_err", bus.err_o, 0);
    check("rand_empty", bus.m_valid_o, 0);
    // random traffic ignoring credits, overflow allowed
    repeat (300) cycle($urandom_range(0, 1), $urandom_range(0, NCH - 1), 8'($urandom), $urandom_range(0, 2) != 0);
    repeat (12) cycle(0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vc_vr_arb_converter.md
VC_VR_ARB_CONVERTER -- requirements
Module: vc_vr_arb_converter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: payload width in bits.
REQ-002 SHALL have parameter CREDIT_NUM, default 2: per-channel buffer depth and initial sender credit count; legal range 1..16.
REQ-003 SHALL have parameter NUM_CH, default 4: number of virtual channels; legal range 1..16; CH_W = max(1, clog2(NUM_CH)).
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 s_data_i  input  DATA_WIDTH  sender payload.
REQ-007 s_ch_i  input  CH_W  sender channel id.
REQ-008 s_valid_i  input  1  sender beat valid; no backpressure on this side.
REQ-009 s_credit_o  output  NUM_CH  per-channel credit return, one pulse = one credit.
REQ-010 m_data_o  output  DATA_WIDTH  receiver payload.
REQ-011 m_ch_o  output  CH_W  channel id of current beat.
REQ-012 m_valid_o  output  1  receiver beat valid.
REQ-013 m_ready_i  input  1  receiver ready.
REQ-014 err_o  output  1  sticky protocol-error flag.

Function
REQ-015 Each channel SHALL own a FIFO of depth CREDIT_NUM with a count register of width clog2(CREDIT_NUM+1).
REQ-016 Beat with s_valid_i=1 at an edge SHALL be written to FIFO[s_ch_i] at that edge if count < CREDIT_NUM or that channel pops at the same edge.
REQ-017 Write to a full, non-popping channel SHALL be dropped and set err_o; FIFO contents unchanged.
REQ-018 s_ch_i >= NUM_CH with s_valid_i=1 SHALL be dropped and set err_o.
REQ-019 Output SHALL be a single register stage (m_valid_o, m_data_o, m_ch_o), all driven from flops.
REQ-020 Output register SHALL load at an edge when (m_valid_o=0 or m_ready_i=1) and at least one FIFO is non-empty; that FIFO pops at the same edge.
REQ-021 While m_valid_o=1 and m_ready_i=0, m_data_o and m_ch_o SHALL hold stable.
REQ-022 m_valid_o SHALL clear at an edge with m_valid_o=1, m_ready_i=1 and all FIFOs empty.
REQ-023 Grant SHALL be round-robin: search non-empty channels from (last_grant+1) mod NUM_CH upward with wrap; last_grant updates only on a pop.
REQ-024 Write at edge k into an empty block SHALL give m_valid_o=1 after edge k+1 (capture-to-valid latency 1 cycle); a FIFO write is never bypassed to the output.
REQ-025 s_credit_o[c] SHALL be 1 for exactly the cycle after each edge at which FIFO[c] pops; at most one bit set per cycle.
REQ-026 Full throughput SHALL be sustained: with m_ready_i held 1 and data available, one beat per cycle.
REQ-027 NUM_CH=1 SHALL reduce to a single-channel converter with m_ch_o constant 0.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear: all FIFO counts and pointers, m_valid_o=0, m_data_o=0, m_ch_o=0, s_credit_o=0, err_o=0, last_grant=NUM_CH-1 (channel 0 wins first).
REQ-029 Reset mid-operation SHALL discard all buffered and in-flight beats with no credit pulses; the sender restarts with CREDIT_NUM credits per channel.
REQ-030 No credit pulses SHALL be emitted at or after reset release; initial credits are implicit.
REQ-031 err_o SHALL clear only by reset.

Verification
REQ-032 Reset 10 cycles, release -> all outputs 0, every channel count 0, err_o=0.
REQ-033 Ch1 beat 0xA5 at edge k, m_ready_i=1 -> m_valid_o=1, m_data_o=0xA5, m_ch_o=1 after edge k+1; s_credit_o=4'b0010 for one cycle after edge k+1.
REQ-034 Two beats each to ch0..ch3 with m_ready_i=0, then m_ready_i=1 -> output order ch0,ch1,ch2,ch3,ch0,ch1,ch2,ch3, data in per-channel FIFO order, 8 credit pulses total, err_o=0.
REQ-035 Third beat to ch2 with ch2 full and m_ready_i=0 -> beat dropped, err_o=1, later drains exactly 2 ch2 beats.
REQ-036 m_ready_i=0 for 5 cycles with m_valid_o=1 -> m_data_o/m_ch_o unchanged; no extra pops or credits.
REQ-037 rst_n low mid-burst with 3 beats buffered -> m_valid_o=0 immediately, no credit pulses, next beat after release passes with REQ-024 latency.
